// File: rtl/npu_pkg.sv
// Shared types and size helpers for the NPU conv-window sequencer.
package npu_pkg;

    localparam int unsigned RES_W = 24;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FILL,
        CALC,
        EMIT,
        SHIFT,
        DONE
    } seq_state_e;

    function automatic int unsigned out_h(input int unsigned in_h, input int unsigned k_h);
        return in_h - k_h + 1;
    endfunction

    function automatic int unsigned out_w(input int unsigned in_w, input int unsigned k_w);
        return in_w - k_w + 1;
    endfunction

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/win_pos_cnt.sv
// 2-D output-window position counter: ocol runs fastest, wraps into orow.
module win_pos_cnt #(
    parameter int unsigned ROWS  = 14,
    parameter int unsigned COLS  = 13,
    parameter int unsigned ROW_W = 4,
    parameter int unsigned COL_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [COL_W-1:0] ocol_o,
    output logic [ROW_W-1:0] orow_o,
    output logic [COL_W-1:0] ocol_nxt_c,
    output logic [ROW_W-1:0] orow_nxt_c,
    output logic             col_last_c,
    output logic             last_c
);

    logic [COL_W-1:0] ocol_q, ocol_d;
    logic [ROW_W-1:0] orow_q, orow_d;
    logic             row_last;

    assign col_last_c = (ocol_q == COL_W'(COLS - 1));
    assign row_last   = (orow_q == ROW_W'(ROWS - 1));
    assign last_c     = col_last_c && row_last;

    // Row advance only on column wrap; the final row holds.
    always_comb begin
        ocol_d = ocol_q;
        orow_d = orow_q;
        if (clr_i) begin
            ocol_d = '0;
            orow_d = '0;
        end else if (inc_i) begin
            if (col_last_c) begin
                ocol_d = '0;
                if (!row_last) begin
                    orow_d = orow_q + ROW_W'(1);
                end
            end else begin
                ocol_d = ocol_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ocol_q <= '0;
            orow_q <= '0;
        end else begin
            ocol_q <= ocol_d;
            orow_q <= orow_d;
        end
    end

    assign ocol_o     = ocol_q;
    assign orow_o     = orow_q;
    assign ocol_nxt_c = ocol_d;
    assign orow_nxt_c = orow_d;

endmodule

// File: rtl/conv_win_seq.sv
// Frame sequencer: walks the KxK window over the image buffer, drives the
// window register and conv unit, and streams ReLU'd results with backpressure.
module conv_win_seq
    import npu_pkg::*;
#(
    parameter int unsigned IN_H   = 16,
    parameter int unsigned IN_W   = 15,
    parameter int unsigned K_H    = 3,
    parameter int unsigned K_W    = 3,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned OUT_AW = 8,
    parameter int unsigned RELU   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              col_rd_en,
    output logic [ADDR_W-1:0] col_rd_addr,
    output logic              win_clear,
    output logic              win_load_en,
    output logic              pe_start,
    input  logic              pe_valid,
    input  logic [RES_W-1:0]  pe_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_AW-1:0] out_addr,
    output logic [RES_W-1:0]  out_data
);

    localparam int unsigned OUT_H = out_h(IN_H, K_H);
    localparam int unsigned OUT_W = out_w(IN_W, K_W);
    localparam int unsigned ROW_W = cnt_w(OUT_H);
    localparam int unsigned COL_W = cnt_w(OUT_W);
    localparam int unsigned FC_W  = cnt_w(K_W + 1);

    seq_state_e state_q, state_d;
    logic [FC_W-1:0] fcnt_q, fcnt_d;
    logic [FC_W-1:0] rd_off;

    logic              pos_clr, pos_inc;
    logic [COL_W-1:0]  ocol, ocol_nxt;
    logic [ROW_W-1:0]  orow, orow_nxt;
    logic              col_last, last_win;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              win_clear_q, win_clear_d;
    logic              load_en_q;
    logic              pe_start_q, pe_start_d;
    logic              out_valid_q, out_valid_d;
    logic [OUT_AW-1:0] out_addr_q, out_addr_d;
    logic [RES_W-1:0]  out_data_q, out_data_d;

    win_pos_cnt #(
        .ROWS  (OUT_H),
        .COLS  (OUT_W),
        .ROW_W (ROW_W),
        .COL_W (COL_W)
    ) u_pos (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (pos_clr),
        .inc_i      (pos_inc),
        .ocol_o     (ocol),
        .orow_o     (orow),
        .ocol_nxt_c (ocol_nxt),
        .orow_nxt_c (orow_nxt),
        .col_last_c (col_last),
        .last_c     (last_win)
    );

    // Next state; outputs are decoded from the next state so they register in step.
    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        pos_clr     = 1'b0;
        pos_inc     = 1'b0;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                    pos_clr = 1'b1;
                end
            end
            CLEAR: begin
                state_d = FILL;
                fcnt_d  = '0;
            end
            FILL: begin
                if (fcnt_q == FC_W'(K_W)) begin
                    state_d = CALC;
                end else begin
                    fcnt_d = fcnt_q + FC_W'(1);
                end
            end
            CALC: begin
                if (pe_valid) begin
                    state_d    = EMIT;
                    out_addr_d = OUT_AW'(orow) * OUT_AW'(OUT_W) + OUT_AW'(ocol);
                    out_data_d = ((RELU != 0) && pe_result[RES_W-1]) ? '0 : pe_result;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (last_win) begin
                        state_d = DONE;
                    end else begin
                        pos_inc = 1'b1;
                        if (col_last) begin
                            state_d = CLEAR;
                        end else begin
                            state_d = SHIFT;
                            fcnt_d  = '0;
                        end
                    end
                end
            end
            SHIFT: begin
                if (fcnt_q == FC_W'(1)) begin
                    state_d = CALC;
                end else begin
                    fcnt_d = FC_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d      = (state_d != IDLE) && (state_d != DONE);
        done_d      = (state_d == DONE);
        win_clear_d = (state_d == CLEAR);
        pe_start_d  = (state_d == CALC) && (state_q != CALC);
        out_valid_d = (state_d == EMIT);
        rd_en_d     = ((state_d == FILL) && (fcnt_d < FC_W'(K_W))) ||
                      ((state_d == SHIFT) && (fcnt_d == '0));
        rd_off      = (state_d == FILL) ? fcnt_d : FC_W'(K_W - 1);
        // Counter next-values give the post-increment position on EMIT->SHIFT.
        rd_addr_d   = rd_en_d ? (ADDR_W'(orow_nxt) * ADDR_W'(IN_W) + ADDR_W'(ocol_nxt)
                                 + ADDR_W'(rd_off)) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            fcnt_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            win_clear_q <= 1'b0;
            load_en_q   <= 1'b0;
            pe_start_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            win_clear_q <= win_clear_d;
            load_en_q   <= rd_en_q;
            pe_start_q  <= pe_start_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign col_rd_en   = rd_en_q;
    assign col_rd_addr = rd_addr_q;
    assign win_clear   = win_clear_q;
    assign win_load_en = load_en_q;
    assign pe_start    = pe_start_q;
    assign out_valid   = out_valid_q;
    assign out_addr    = out_addr_q;
    assign out_data    = out_data_q;

endmodule

// File: tb/tb_conv_win_seq.sv
// Directed bench for conv_win_seq: timing of the first windows, row wrap,
// backpressure, a full 182-window frame and reset/start/pe_valid robustness.
module tb_conv_win_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        col_rd_en;
    logic [7:0]  col_rd_addr;
    logic        win_clear;
    logic        win_load_en;
    logic        pe_start;
    logic        pe_valid;
    logic [23:0] pe_result;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_addr;
    logic [23:0] out_data;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    conv_win_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .col_rd_en   (col_rd_en),
        .col_rd_addr (col_rd_addr),
        .win_clear   (win_clear),
        .win_load_en (win_load_en),
        .pe_start    (pe_start),
        .pe_valid    (pe_valid),
        .pe_result   (pe_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_addr    (out_addr),
        .out_data    (out_data)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pe_start(input string tag);
        int n = 0;
        while (pe_start !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check({tag, " pe_start"}, 64'(pe_start), 64'd1);
    endtask

    // Conv model: result valid two cycles after pe_start.
    task automatic pe_respond(input int res);
        tick();
        tick();
        pe_valid  = 1'b1;
        pe_result = 24'(res);
        tick();
        pe_valid  = 1'b0;
    endtask

    task automatic accept();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic process_window(input int idx, input int res);
        int exp_d;
        exp_d = (res < 0) ? 0 : res;
        wait_pe_start($sformatf("win%0d", idx));
        pe_respond(res);
        check($sformatf("win%0d out_valid", idx), 64'(out_valid), 64'd1);
        check($sformatf("win%0d out_addr", idx), 64'(out_addr), 64'(idx));
        check($sformatf("win%0d out_data", idx), 64'(out_data), 64'(24'(exp_d)));
        accept();
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({busy, done, col_rd_en, col_rd_addr, win_clear, win_load_en,
                    pe_start, out_valid, out_addr, out_data});
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; pe_valid = 1'b0; pe_result = '0; out_ready = 1'b0;
        #1;
        check("reset outputs", all_outs(), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Basic first window timing (cycle 0 = start).
        start = 1'b1;
        tick();
        start = 1'b0;
        check("c1 win_clear", 64'(win_clear), 64'd1);
        check("c1 busy", 64'(busy), 64'd1);
        tick();
        check("c2 rd", 64'({col_rd_en, col_rd_addr, win_load_en}), 64'({1'b1, 8'd0, 1'b0}));
        tick();
        check("c3 rd", 64'({col_rd_en, col_rd_addr, win_load_en}), 64'({1'b1, 8'd1, 1'b1}));
        tick();
        check("c4 rd", 64'({col_rd_en, col_rd_addr, win_load_en}), 64'({1'b1, 8'd2, 1'b1}));
        tick();
        check("c5 load", 64'({col_rd_en, win_load_en, pe_start}), 64'({1'b0, 1'b1, 1'b0}));
        tick();
        check("c6 pe_start", 64'(pe_start), 64'd1);
        pe_respond(-5);
        check("w0 out_valid", 64'(out_valid), 64'd1);
        check("w0 out_data relu", 64'(out_data), 64'd0);
        check("w0 out_addr", 64'(out_addr), 64'd0);
        accept();

        // Shift: single read of new rightmost column.
        check("shift rd", 64'({col_rd_en, col_rd_addr}), 64'({1'b1, 8'd3}));
        tick();
        check("shift load", 64'({col_rd_en, win_load_en}), 64'({1'b0, 1'b1}));
        tick();
        check("shift pe_start", 64'(pe_start), 64'd1);
        pe_respond(100);
        check("w1 out_addr", 64'(out_addr), 64'd1);
        check("w1 out_data", 64'(out_data), 64'd100);
        accept();

        for (int i = 2; i <= 12; i++) process_window(i, i * 3);

        // Row wrap: full refill of the next row.
        check("wrap win_clear", 64'(win_clear), 64'd1);
        tick();
        check("wrap rd0", 64'({col_rd_en, col_rd_addr}), 64'({1'b1, 8'd15}));
        tick();
        check("wrap rd1", 64'({col_rd_en, col_rd_addr}), 64'({1'b1, 8'd16}));
        tick();
        check("wrap rd2", 64'({col_rd_en, col_rd_addr}), 64'({1'b1, 8'd17}));

        // Backpressure on window 13.
        wait_pe_start("win13");
        pe_respond(-7);
        check("w13 out_addr", 64'(out_addr), 64'd13);
        for (int s = 0; s < 5; s++) begin
            tick();
            check($sformatf("stall%0d", s), 64'({out_valid, out_addr, out_data, col_rd_en}),
                  64'({1'b1, 8'd13, 24'd0, 1'b0}));
        end
        accept();
        check("release out_valid", 64'(out_valid), 64'd0);
        check("release rd", 64'({col_rd_en, col_rd_addr}), 64'({1'b1, 8'd18}));

        // Remainder of the frame.
        for (int i = 14; i <= 181; i++) process_window(i, (i % 3 == 0) ? -i : i * 7);
        check("done pulse", 64'({done, busy, out_valid}), 64'({1'b1, 1'b0, 1'b0}));
        tick();
        check("after done", 64'({done, busy}), 64'd0);
        check("done count", 64'(done_cnt), 64'd1);

        // Start while busy and spurious pe_valid during FILL are ignored.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; pe_valid = 1'b1; pe_result = 24'd55;
        tick();
        start = 1'b0; pe_valid = 1'b0;
        check("busy start ignored", 64'({win_clear, col_rd_en, col_rd_addr}), 64'({1'b0, 1'b1, 8'd1}));
        tick();
        tick();
        tick();
        check("spurious pe_valid", 64'({pe_start, out_valid}), 64'({1'b1, 1'b0}));
        tick();
        tick();
        tick();
        check("no emit without pe_valid", 64'(out_valid), 64'd0);

        // Reset during FILL aborts, then a fresh start replays from addr 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("fill before rst", 64'({col_rd_en, col_rd_addr, win_load_en}), 64'({1'b1, 8'd1, 1'b1}));
        rst = 1'b1;
        #1;
        check("rst in fill outputs", all_outs(), 64'd0);
        tick();
        rst = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("replay win_clear", 64'(win_clear), 64'd1);
        tick();
        check("replay rd0", 64'({col_rd_en, col_rd_addr}), 64'({1'b1, 8'd0}));
        check("no done on abort", 64'(done_cnt), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
